// File: rtl/mac_accumulator.sv
// Two-stage signed multiply-accumulate: stage P registers exact products, stage A
// sums BLOCK_K of them and presents the full-width dot product on a valid/ready port.
module mac_accumulator #(
    parameter int BIT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 8,
    parameter int BLOCK_K    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [BIT_WIDTH-1:0]   a,
    input  logic signed [BIT_WIDTH-1:0]   b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [2*BIT_WIDTH-1:0] out_data,
    output logic [15:0]                   out_last_idx
);

    localparam int PW = 2 * BIT_WIDTH;
    localparam int KW = (BLOCK_K > 1) ? $clog2(BLOCK_K) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(BLOCK_K - 1);

    // Products and sums carry 2*FRAC_WIDTH fractional bits; nothing here rescales them.
    if (BLOCK_K < 1 || FRAC_WIDTH < 0 || FRAC_WIDTH >= BIT_WIDTH) begin : g_param_check
        $error("mac_accumulator: BLOCK_K must be >= 1 and FRAC_WIDTH within the operand");
    end

    logic [KW-1:0]        k_cnt_reg;
    logic                 p_valid_reg;
    logic                 p_last_reg;
    logic signed [PW-1:0] p_reg;
    logic signed [PW-1:0] acc_reg;
    logic                 acc_first_reg;
    logic                 out_valid_reg;
    logic signed [PW-1:0] out_data_reg;
    logic [15:0]          out_idx_reg;

    logic                 fire_in;
    logic                 adv;
    logic                 out_accept;
    logic signed [PW-1:0] prod_next;
    logic signed [PW-1:0] sum_next;

    // Stage A only stalls when it holds a last product and the output slot is still occupied.
    assign adv        = p_valid_reg & ~(p_last_reg & out_valid_reg & ~out_ready) & ~clear;
    assign in_ready   = ~rst & ~clear & (~p_valid_reg | adv);
    assign fire_in    = in_valid & in_ready;
    assign out_accept = out_valid_reg & out_ready;
    assign prod_next  = PW'(a) * PW'(b);
    assign sum_next   = (acc_first_reg ? '0 : acc_reg) + p_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_cnt_reg     <= '0;
            p_valid_reg   <= 1'b0;
            p_last_reg    <= 1'b0;
            p_reg         <= '0;
            acc_reg       <= '0;
            acc_first_reg <= 1'b1;
        end else if (clear) begin
            k_cnt_reg     <= '0;
            p_valid_reg   <= 1'b0;
            acc_first_reg <= 1'b1;
        end else begin
            if (fire_in) begin
                p_reg       <= prod_next;
                p_valid_reg <= 1'b1;
                p_last_reg  <= (k_cnt_reg == K_LAST);
                k_cnt_reg   <= (k_cnt_reg == K_LAST) ? '0 : k_cnt_reg + KW'(1);
            end else if (adv) begin
                p_valid_reg <= 1'b0;
            end
            if (adv) begin
                acc_reg       <= sum_next;
                acc_first_reg <= p_last_reg;
            end
        end
    end

    // A new result and an acceptance in the same cycle keep out_valid high with no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_idx_reg   <= '0;
        end else if (adv && p_last_reg) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= sum_next;
            out_idx_reg   <= out_idx_reg + 16'd1;
        end else if (out_accept) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid    = out_valid_reg;
    assign out_data     = out_data_reg;
    assign out_last_idx = out_idx_reg;

endmodule
